// File: rtl/biriscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// biriscv_alu_arbiter
//
// Shares one pipelined integer ALU between NUM_REQ requesters. The ALU
// registers its inputs and its output, so a result comes back two cycles after
// issue. A 2-stage tag pipeline follows each operation through the ALU, and
// the result is returned to the requester that issued it.
//
// Parameters
//   NUM_REQ       number of requesters (2..4)
//   RR_EN         1 = round-robin, 0 = fixed priority (lowest index wins)
//
// Ports
//   clk, rst      clock shared with the ALU; synchronous active-high reset
//   req_valid_i   per-requester request
//   req_op_i      4-bit ALU opcode per requester, slice i = [4i+3:4i]
//   req_a_i/b_i   32-bit operands per requester, slice i = [32i+31:32i]
//   req_ready_o   one-hot grant (handshake = valid & ready)
//   flush_i       kill in-flight operations and block this cycle's grant
//   alu_op_o/a/b  drive to the shared ALU (zero when nothing is granted)
//   alu_p_i       ALU result
//   resp_valid_o  one-hot result valid for the owning requester
//   resp_result_o result data (zero when no response)
//   busy_o        at least one operation in flight
// -----------------------------------------------------------------------------
module biriscv_alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int RR_EN   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [4*NUM_REQ-1:0]    req_op_i,
    input  logic [32*NUM_REQ-1:0]   req_a_i,
    input  logic [32*NUM_REQ-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic                    flush_i,
    output logic [3:0]              alu_op_o,
    output logic [31:0]             alu_a_o,
    output logic [31:0]             alu_b_o,
    input  logic [31:0]             alu_p_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic [31:0]             resp_result_o,
    output logic                    busy_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic [IDW-1:0]     id1_q, id1_d;
    logic [IDW-1:0]     id2_q, id2_d;

    logic               gnt_any;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [IDW:0]       cand_sum;
    logic [IDW-1:0]     cand;

    // Arbitration. The candidate order starts at ptr_q for round-robin, or at
    // 0 for fixed priority; the extra bit of cand_sum lets the wrap be done
    // with one compare/subtract instead of a modulo.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_vec  = '0;
        cand_sum = '0;
        cand     = '0;
        if (!rst && !flush_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (RR_EN != 0) begin
                    cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
                end else begin
                    cand_sum = (IDW+1)'(k);
                end
                if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
                    cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
                end
                cand = cand_sum[IDW-1:0];
                if (!gnt_any && req_valid_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) begin
                gnt_vec[gnt_idx] = 1'b1;
            end
        end
    end

    assign req_ready_o = gnt_vec;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ALU input mux; an idle cycle issues ALU_NONE with zero operands.
    always_comb begin
        alu_op_o = 4'b0000;
        alu_a_o  = '0;
        alu_b_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                alu_op_o = req_op_i[i*4 +: 4];
                alu_a_o  = req_a_i[i*32 +: 32];
                alu_b_o  = req_b_i[i*32 +: 32];
            end
        end
    end

    // Tag pipeline mirroring the ALU's input and output registers.
    // gnt_any is already forced low by flush_i, so only stage 2 needs the kill.
    always_comb begin
        v1_d  = gnt_any;
        id1_d = gnt_idx;
        v2_d  = v1_q & ~flush_i;
        id2_d = id1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            id1_q <= '0;
            id2_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            id1_q <= id1_d;
            id2_q <= id2_d;
        end
    end

    // Responses are masked during reset so a result already in stage 2 when
    // reset arrives is never presented.
    always_comb begin
        resp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_o[i] = !rst && v2_q && (id2_q == IDW'(i));
        end
    end

    assign resp_result_o = (v2_q && !rst) ? alu_p_i : 32'd0;
    assign busy_o        = v1_q | v2_q;

endmodule
